// File: rtl/ro_meas_ctrl.sv
// ----------------------------------------------------------------------------
// ro_meas_ctrl
//
// Purpose:
//   Measurement controller for the ring-oscillator pair (short/long).
//   It enables one ring, lets it settle for SETTLE_CYC cycles, and counts the
//   synchronized rising edges of that ring over a programmable window. Three
//   drain cycles follow, so edges still in the synchronizer are captured. The
//   result is published on count with a one-cycle done pulse. A sticky alarm
//   is raised when the result falls outside [thr_lo, thr_hi].
//
// Ports:
//   mclk, reset_n         clock, asynchronous active-low reset
//   start, abort          measurement request / immediate stop (abort wins)
//   ro_sel                ring select (0 short, 1 long), sampled on load
//   continuous            run measurements back-to-back while high
//   win_len               counting window in cycles (0 behaves as 1)
//   thr_lo, thr_hi        accepted count band (inclusive)
//   alarm_clr             clears the sticky alarm (a same-cycle set wins)
//   ro_short_q, ro_long_q pre-divided ring outputs (asynchronous)
//   ro_short_en/long_en   ring enables (never both high)
//   busy, done, count     status, result strobe, last result
//   alarm                 sticky out-of-band flag
//   last_sel              (ROCTRL_ALT_EN only) ring behind the current count
//
// Optional feature, macro ROCTRL_ALT_EN:
//   When defined, continuous runs alternate rings after the first
//   measurement, and the last_sel output is added.
// ----------------------------------------------------------------------------
module ro_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ro_sel,
  input  logic             continuous,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic             alarm_clr,
  input  logic             ro_short_q,
  input  logic             ro_long_q,
  output logic             ro_short_en,
  output logic             ro_long_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
`ifdef ROCTRL_ALT_EN
  output logic             last_sel,
`endif
  output logic             alarm
);

  // The phase timer must hold both the settle length and the window length.
  localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST  = TMR_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_COUNT, S_DRAIN, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [WIN_W-1:0]   win_q;
  logic               sel_q, sel_d;
  logic [2:0]         sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               short_en_q, short_en_d;
  logic               long_en_q, long_en_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               alarm_q, alarm_d;
  logic               last_sel_q, last_sel_d;

  logic [WIN_W-1:0]   win_eff;
  logic [TMR_W-1:0]   win_last;
  logic               load_cfg;
  logic               ro_edge;
  logic               out_band;

  assign win_eff  = (win_len == '0) ? WIN_W'(1) : win_len;
  assign win_last = TMR_W'(win_q - WIN_W'(1));

  // Configuration is captured whenever a new SETTLE phase begins, i.e. on an
  // accepted start or on the DONE->SETTLE hop of a continuous run.
  assign load_cfg = (state_d == S_SETTLE) && (state_q != S_SETTLE);

  // Rising edge seen once the sample is two flops deep (third flop = history).
  assign ro_edge  = sync_q[1] & ~sync_q[2];

  // Lexicographic compare: with thr_lo > thr_hi every value is out of band.
  assign out_band = (cnt_q < thr_lo) || (cnt_q > thr_hi);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)                  state_d = S_SETTLE;
      S_SETTLE: if (timer_q == SETTLE_LAST) state_d = S_COUNT;
      S_COUNT:  if (timer_q == win_last)    state_d = S_DRAIN;
      S_DRAIN:  if (timer_q == DRAIN_LAST)  state_d = S_DONE;
      S_DONE:   state_d = continuous ? S_SETTLE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (outputs are registered, one cycle behind the state)
  // --------------------------------------------------------------------------
  always_comb begin
    short_en_d = 1'b0;
    long_en_d  = 1'b0;
    done_d     = 1'b0;
    if (!abort) begin
      if (state_q == S_SETTLE || state_q == S_COUNT) begin
        short_en_d = ~sel_q;
        long_en_d  = sel_q;
      end
      done_d = (state_q == S_DONE);
    end
    count_d    = done_d ? cnt_q : count_q;
    alarm_d    = (done_d & out_band) | (alarm_q & ~alarm_clr);
    last_sel_d = done_d ? sel_q : last_sel_q;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_comb begin
    timer_d = timer_q + TMR_W'(1);
    if (state_d != state_q || state_q == S_IDLE) timer_d = '0;

    sel_d = ro_sel;
`ifdef ROCTRL_ALT_EN
    // Continuous runs alternate rings; only the first follows ro_sel.
    if (state_q == S_DONE) sel_d = ~sel_q;
`endif

    cnt_d = cnt_q;
    if (state_q == S_SETTLE && state_d == S_COUNT) begin
      cnt_d = '0;
    end else if ((state_q == S_COUNT || state_q == S_DRAIN) && ro_edge &&
                 (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q    <= '0;
      win_q      <= WIN_W'(1);
      sel_q      <= 1'b0;
      sync_q     <= '0;
      cnt_q      <= '0;
      short_en_q <= 1'b0;
      long_en_q  <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      alarm_q    <= 1'b0;
      last_sel_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      if (load_cfg) begin
        win_q <= win_eff;
        sel_q <= sel_d;
      end
      sync_q     <= {sync_q[1:0], (sel_q ? ro_long_q : ro_short_q)};
      cnt_q      <= cnt_d;
      short_en_q <= short_en_d;
      long_en_q  <= long_en_d;
      done_q     <= done_d;
      count_q    <= count_d;
      alarm_q    <= alarm_d;
      last_sel_q <= last_sel_d;
    end
  end

  assign ro_short_en = short_en_q;
  assign ro_long_en  = long_en_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign count       = count_q;
  assign alarm       = alarm_q;
`ifdef ROCTRL_ALT_EN
  assign last_sel    = last_sel_q;
`else
  logic unused_last_sel;
  assign unused_last_sel = last_sel_q;
`endif

endmodule

// File: tb/tb_ro_meas_ctrl.sv
module tb_ro_meas_ctrl;

  logic        mclk;
  logic        reset_n;
  logic        start, abort, ro_sel, continuous, alarm_clr;
  logic [15:0] win_len, thr_lo, thr_hi;
  logic        ro_short_q, ro_long_q;
  logic        ro_short_en, ro_long_en, busy, done, alarm;
  logic [15:0] count;
`ifdef ROCTRL_ALT_EN
  logic        last_sel;
`endif

  // Second instance with a 4-bit counter for the saturation case.
  logic        start_s;
  logic [15:0] win_s;
  logic [3:0]  thr_lo_s, thr_hi_s;
  logic        sen_s, len_s, busy_s, done_s, alarm_s;
  logic [3:0]  count_s;
`ifdef ROCTRL_ALT_EN
  logic        last_sel_s;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ro_meas_ctrl u_dut (
    .mclk(mclk), .reset_n(reset_n), .start(start), .abort(abort),
    .ro_sel(ro_sel), .continuous(continuous), .win_len(win_len),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .alarm_clr(alarm_clr),
    .ro_short_q(ro_short_q), .ro_long_q(ro_long_q),
    .ro_short_en(ro_short_en), .ro_long_en(ro_long_en), .busy(busy),
    .done(done), .count(count),
`ifdef ROCTRL_ALT_EN
    .last_sel(last_sel),
`endif
    .alarm(alarm)
  );

  ro_meas_ctrl #(.CNT_W(4)) u_sat (
    .mclk(mclk), .reset_n(reset_n), .start(start_s), .abort(1'b0),
    .ro_sel(1'b1), .continuous(1'b0), .win_len(win_s),
    .thr_lo(thr_lo_s), .thr_hi(thr_hi_s), .alarm_clr(1'b0),
    .ro_short_q(ro_short_q), .ro_long_q(ro_long_q),
    .ro_short_en(sen_s), .ro_long_en(len_s), .busy(busy_s),
    .done(done_s), .count(count_s),
`ifdef ROCTRL_ALT_EN
    .last_sel(last_sel_s),
`endif
    .alarm(alarm_s)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Ring models: short ring rises every 8 mclk, long ring every 4 mclk.
  logic [7:0] phase = 8'd0;
  always @(negedge mclk) begin
    phase      = phase + 8'd1;
    ro_short_q = phase[2];
    ro_long_q  = phase[1];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Runs until done (edge index relative to the last start), watching enables.
  int  done_at;
  bit  short_seen, long_seen;
  task automatic wait_done(input int limit);
    done_at    = -1;
    short_seen = 0;
    long_seen  = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (ro_short_en) short_seen = 1;
      if (ro_long_en)  long_seen  = 1;
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int  first_en, last_en, en_cnt, nd, cnt_before;
  int  de [1:4];
  bit  flag;

  initial begin
    reset_n = 1'b0; start = 0; abort = 0; ro_sel = 0; continuous = 0;
    alarm_clr = 0; win_len = 16'd64; thr_lo = 16'd6; thr_hi = 16'd10;
    start_s = 0; win_s = 16'd100; thr_lo_s = 4'd0; thr_hi_s = 4'd15;

    // ---- Reset / idle ----
    repeat (5) tick();
    check("rst_count", 32'(count), 0);
    check("rst_outs", 32'({ro_short_en, ro_long_en, busy, done, alarm}), 0);
    reset_n = 1'b1;
    flag = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ro_short_en || ro_long_en || busy || done) flag = 1;
    end
    check("idle_quiet", 32'(flag), 0);

    // ---- Single short measurement: enables 1..72, done at 76 ----
    ro_sel = 0; win_len = 16'd64; thr_lo = 16'd6; thr_hi = 16'd10;
    pulse_start();
    first_en = -1; last_en = -1; en_cnt = 0; done_at = -1; flag = 0;
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (ro_short_en) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (ro_long_en) flag = 1;
      if (done && done_at < 0) done_at = k;
    end
    check("short_en_first", first_en, 1);
    check("short_en_last", last_en, 72);
    check("short_en_cycles", en_cnt, 72);
    check("short_done_edge", done_at, 76);
    check("short_no_long_en", 32'(flag), 0);
    check("short_count_8pm1", 32'(count >= 16'd7 && count <= 16'd9), 1);
    check("short_alarm", 32'(alarm), 0);
    check("short_idle_busy", 32'(busy), 0);

    // ---- Alarm band: long ring, ~16 edges vs thr_hi=10 ----
    ro_sel = 1; thr_lo = 16'd0; thr_hi = 16'd10;
    pulse_start();
    wait_done(200);
    check("long_done_edge", done_at, 76);
    check("long_no_short_en", 32'(short_seen), 0);
    check("long_count_16pm1", 32'(count >= 16'd15 && count <= 16'd17), 1);
    check("long_alarm_set", 32'(alarm), 1);
    alarm_clr = 1; tick(); alarm_clr = 0;
    check("alarm_cleared", 32'(alarm), 0);
    // alarm_clr held across an alarming done: set wins.
    alarm_clr = 1;
    pulse_start();
    wait_done(200);
    check("alarm_set_wins", 32'(alarm), 1);
    tick();
    alarm_clr = 0;
    check("alarm_clr_after", 32'(alarm), 0);
    // Inverted band: every measurement alarms.
    ro_sel = 0; thr_lo = 16'd20; thr_hi = 16'd5;
    pulse_start();
    wait_done(200);
    check("inv_band_alarm", 32'(alarm), 1);
    alarm_clr = 1; tick(); alarm_clr = 0;

    // ---- Abort at edge 20 ----
    ro_sel = 0; win_len = 16'd64; thr_lo = 16'd0; thr_hi = 16'd100;
    cnt_before = 32'(count);
    pulse_start();
    repeat (19) tick();
    check("pre_abort_en", 32'(ro_short_en), 1);
    abort = 1; tick(); abort = 0;
    tick();
    check("abort_en_low", 32'({ro_short_en, ro_long_en}), 0);
    check("abort_busy", 32'(busy), 0);
    flag = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done) flag = 1;
    end
    check("abort_no_done", 32'(flag), 0);
    check("abort_count_kept", 32'(count), cnt_before);

    // ---- start and abort together ----
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    tick();
    check("start_abort_idle", 32'({busy, ro_short_en, ro_long_en}), 0);

    // ---- start while busy at edge 30 is ignored ----
    ro_sel = 0; win_len = 16'd64;
    pulse_start();
    repeat (29) tick();
    ro_sel = 1; win_len = 16'd4; start = 1;
    tick();
    start = 0; ro_sel = 0; win_len = 16'd64;
    wait_done(100);
    check("busy_start_done_edge", done_at + 30, 76);
    check("busy_start_no_long", 32'(long_seen), 0);

    // ---- Continuous with win_len = 0: done every 13 cycles ----
    continuous = 1; win_len = 16'd0; ro_sel = 0;
    pulse_start();
    nd = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done) begin
        nd++;
        if (nd <= 4) de[nd] = k;
        if (nd == 3) continuous = 0;
      end
    end
    check("cont_done1", de[1], 13);
    check("cont_done2", de[2], 26);
    check("cont_done3", de[3], 39);
    check("cont_done4", de[4], 52);
    check("cont_total_dones", nd, 4);
    check("cont_end_idle", 32'(busy), 0);

    // ---- Saturation on the 4-bit instance ----
    start_s = 1; tick(); start_s = 0;
    flag = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done_s) begin
        flag = 1;
        break;
      end
    end
    check("sat_done_seen", 32'(flag), 1);
    check("sat_count", 32'(count_s), 15);

`ifdef ROCTRL_ALT_EN
    // ---- Alternating rings in continuous mode ----
    continuous = 1; win_len = 16'd2; ro_sel = 0;
    pulse_start();
    nd = 0;
    for (int k = 1; k <= 200 && nd < 4; k++) begin
      tick();
      if (done) begin
        nd++;
        check($sformatf("alt_last_sel%0d", nd), 32'(last_sel), (nd % 2 == 1) ? 0 : 1);
        if (nd == 3) continuous = 0;
      end
    end
    check("alt_dones", nd, 4);
    repeat (20) tick();
`endif

    // ---- Asynchronous reset mid-COUNT ----
    ro_sel = 0; win_len = 16'd64; thr_lo = 16'd0; thr_hi = 16'd0;
    pulse_start();
    wait_done(200);
    check("pre_reset_count_nz", 32'(count != 16'd0), 1);
    pulse_start();
    repeat (20) tick();
    check("pre_reset_en", 32'(ro_short_en), 1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_outs", 32'({ro_short_en, ro_long_en, busy, done, alarm}), 0);
    check("areset_count", 32'(count), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
